// File: rtl/memory_bank_power_ctrl.sv
// memory_bank_power_ctrl: banked single-port SRAM with a per-bank power FSM
// (ACTIVE / WAKING / SLEEP), idle-timeout auto-sleep, software forced sleep
// and a fixed wake-up latency. Requests to a non-ACTIVE bank stall on req_ready.
// Optional feature macro: MEMBANK_WAKE_CNT_EN adds bank_wake_cnt, a saturating
// per-bank count of SLEEP->WAKING transitions.
module memory_bank_power_ctrl #(
  parameter int unsigned NUM_BANKS    = 4,
  parameter int unsigned BANK_DEPTH   = 256,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned WAKE_CYCLES  = 4,
  parameter int unsigned IDLE_TIMEOUT = 16,
  parameter int unsigned ADDR_W       = $clog2(NUM_BANKS * BANK_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  input  logic [NUM_BANKS-1:0]     force_sleep,
  output logic [NUM_BANKS-1:0]     bank_pwr_en,
  output logic [2*NUM_BANKS-1:0]   bank_state
`ifdef MEMBANK_WAKE_CNT_EN
  ,
  output logic [16*NUM_BANKS-1:0]  bank_wake_cnt
`endif
);

  localparam int unsigned WORD_W     = $clog2(BANK_DEPTH);
  localparam int unsigned BANK_W     = $clog2(NUM_BANKS);
  localparam int unsigned WAKE_W     = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam int unsigned IDLE_W     = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam int unsigned IDLE_LAST  = (IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0;
  localparam int unsigned WAKE_LOAD  = WAKE_CYCLES - 1;
  localparam bit          AUTO_SLEEP = (IDLE_TIMEOUT != 0);

  localparam logic [1:0] ST_ACTIVE = 2'b00;
  localparam logic [1:0] ST_WAKING = 2'b01;
  localparam logic [1:0] ST_SLEEP  = 2'b10;

  logic [1:0]            state_q [NUM_BANKS];
  logic [1:0]            state_d [NUM_BANKS];
  logic [IDLE_W-1:0]     idle_q  [NUM_BANKS];
  logic [IDLE_W-1:0]     idle_d  [NUM_BANKS];
  logic [WAKE_W-1:0]     wake_q  [NUM_BANKS];
  logic [WAKE_W-1:0]     wake_d  [NUM_BANKS];

  logic [BANK_W-1:0]     tgt;
  logic [WORD_W-1:0]     word;
  logic                  accept;
  logic [NUM_BANKS-1:0]  req_bank;
  logic [NUM_BANKS-1:0]  acc_bank;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

  assign tgt  = req_addr[ADDR_W-1:WORD_W];
  assign word = req_addr[WORD_W-1:0];

  // Accept only when the target bank is powered and not being forced down
  assign req_ready = (state_q[tgt] == ST_ACTIVE) && !force_sleep[tgt];
  assign accept    = req_valid && req_ready;
  assign req_bank  = req_valid ? (NUM_BANKS'(1) << tgt) : '0;
  assign acc_bank  = accept ? (NUM_BANKS'(1) << tgt) : '0;

  // Per-bank next-state, idle counter and wake counter
  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      state_d[i] = state_q[i];
      idle_d[i]  = idle_q[i];
      wake_d[i]  = wake_q[i];
      case (state_q[i])
        ST_ACTIVE: begin
          if (force_sleep[i]) begin
            state_d[i] = ST_SLEEP;
            idle_d[i]  = '0;
          end else if (acc_bank[i]) begin
            idle_d[i] = '0;
          end else if (AUTO_SLEEP && (idle_q[i] == IDLE_W'(IDLE_LAST))) begin
            state_d[i] = ST_SLEEP;
            idle_d[i]  = '0;
          end else if (AUTO_SLEEP) begin
            idle_d[i] = idle_q[i] + IDLE_W'(1);
          end
        end
        ST_SLEEP: begin
          if (req_bank[i] && !force_sleep[i]) begin
            state_d[i] = ST_WAKING;
            wake_d[i]  = WAKE_W'(WAKE_LOAD);
          end
        end
        ST_WAKING: begin
          if (force_sleep[i]) begin
            state_d[i] = ST_SLEEP;
            wake_d[i]  = '0;
          end else if (wake_q[i] == '0) begin
            state_d[i] = ST_ACTIVE;
            idle_d[i]  = '0;
          end else begin
            wake_d[i] = wake_q[i] - WAKE_W'(1);
          end
        end
        default: begin
          state_d[i] = ST_ACTIVE;
          idle_d[i]  = '0;
          wake_d[i]  = '0;
        end
      endcase
    end
  end

  // Power FSM state and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        state_q[i] <= ST_ACTIVE;
        idle_q[i]  <= '0;
        wake_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        state_q[i] <= state_d[i];
        idle_q[i]  <= idle_d[i];
        wake_q[i]  <= wake_d[i];
      end
    end
  end

  // Status outputs decoded straight from the state flops
  always_comb begin
    bank_state  = '0;
    bank_pwr_en = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      bank_state[2*i +: 2] = state_q[i];
      bank_pwr_en[i]       = (state_q[i] != ST_SLEEP);
    end
  end

  // One RAM macro per bank; contents are retained while the bank sleeps
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] ram [BANK_DEPTH];

    // Write port, only reachable through an accepted request
    always_ff @(posedge clk) begin
      if (acc_bank[b] && req_we) begin
        ram[word] <= req_wdata;
      end
    end

    assign bank_rdata[b] = ram[word];
  end

  // Registered read response; rdata holds its value between responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= accept && !req_we;
      if (accept && !req_we) begin
        rsp_rdata <= bank_rdata[tgt];
      end
    end
  end

`ifdef MEMBANK_WAKE_CNT_EN
  logic [15:0] wake_cnt_q [NUM_BANKS];

  // Saturating count of SLEEP->WAKING transitions per bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        wake_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if ((state_q[i] == ST_SLEEP) && (state_d[i] == ST_WAKING) &&
            (wake_cnt_q[i] != 16'hFFFF)) begin
          wake_cnt_q[i] <= wake_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // Pack the per-bank counters onto the output bus
  always_comb begin
    bank_wake_cnt = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      bank_wake_cnt[16*i +: 16] = wake_cnt_q[i];
    end
  end
`else
  // Wake counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_memory_bank_power_ctrl.sv
// Testbench for memory_bank_power_ctrl with default parameters.
// Read data is scored against a reference memory through an expectation queue;
// power-state timing is checked against absolute cycle numbers.
// Build with MEMBANK_WAKE_CNT_EN defined to also check bank_wake_cnt.
module tb_memory_bank_power_ctrl;

  localparam int unsigned NUM_BANKS  = 4;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_W     = 10;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_W-1:0]       req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic [NUM_BANKS-1:0]    force_sleep;
  logic [NUM_BANKS-1:0]    bank_pwr_en;
  logic [2*NUM_BANKS-1:0]  bank_state;
`ifdef MEMBANK_WAKE_CNT_EN
  logic [16*NUM_BANKS-1:0] bank_wake_cnt;
`endif

  memory_bank_power_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .force_sleep (force_sleep),
    .bank_pwr_en (bank_pwr_en),
    .bank_state  (bank_state)
`ifdef MEMBANK_WAKE_CNT_EN
    ,
    .bank_wake_cnt (bank_wake_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int w;
  int a;
  int a0;
  int a1;

  logic [DATA_WIDTH-1:0] model [1024];
  logic [DATA_WIDTH-1:0] exp_q [$];
  logic                  exp_rsp = 1'b0;
  logic [DATA_WIDTH-1:0] exp_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Scoreboard: push expected read data on acceptance, pop when the response is due
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_rsp = 1'b0;
    end else begin
      if (exp_rsp || rsp_valid) check("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
      if (exp_rsp && exp_q.size() > 0) begin
        exp_data = exp_q.pop_front();
        if (rsp_valid) check("rsp_rdata", 64'(rsp_rdata), 64'(exp_data));
      end
      exp_rsp = 1'b0;
      if (req_valid && req_ready) begin
        if (req_we) model[req_addr] = req_wdata;
        else begin
          exp_q.push_back(model[req_addr]);
          exp_rsp = 1'b1;
        end
      end
    end
  end

  // Present one request and hold it until accepted; returns stall count and acceptance cycle
  task automatic do_req(input logic we, input logic [ADDR_W-1:0] ad, input logic [DATA_WIDTH-1:0] d,
                        output int waited, output int acc_cyc);
    logic done;
    done    = 1'b0;
    waited  = 0;
    acc_cyc = 0;
    req_we    = we;
    req_addr  = ad;
    req_wdata = d;
    req_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (req_ready) done = 1'b1;
      else begin
        waited++;
        if (waited > 40) begin
          check("req_timeout", 64'(waited), 64'd40);
          done = 1'b1;
        end else begin
          @(posedge clk); #1;
        end
      end
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; force_sleep = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_state", 64'(bank_state), 64'h00);
    check("rst_pwr", 64'(bank_pwr_en), 64'hF);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // Basic write/read to an active bank
    do_req(1'b1, 10'h005, 32'hDEADBEEF, w, a);
    check("t1_wr_wait", 64'(w), 64'd0);
    do_req(1'b0, 10'h005, 32'h0, w, a);
    check("t1_rd_wait", 64'(w), 64'd0);

    // Seed bank 2 for the retention check
    do_req(1'b1, 10'h2A5, 32'hA5A5_0002, w, a);

    // Independent idle timeouts on banks 0 and 1
    do_req(1'b1, 10'h010, 32'h0000_0010, w, a0);
    do_req(1'b1, 10'h13C, 32'h1111_013C, w, a1);
    while (cyc <= a1 + 18) begin
      @(negedge clk);
      check("t2_b0_state", 64'(bank_state[1:0]), (cyc >= a0 + 17) ? 64'h2 : 64'h0);
      check("t2_b1_state", 64'(bank_state[3:2]), (cyc >= a1 + 17) ? 64'h2 : 64'h0);
      check("t2_b1_pwr", 64'(bank_pwr_en[1]), (cyc >= a1 + 17) ? 64'd0 : 64'd1);
      @(posedge clk); #1;
    end

    // Wake-on-request with retention
    check("t3_b2_sleep", 64'(bank_state[5:4]), 64'h2);
    check("t3_b2_pwr", 64'(bank_pwr_en[2]), 64'd0);
    do_req(1'b0, 10'h2A5, 32'h0, w, a);
    check("t3_wake_wait", 64'(w), 64'd5);

    // Stream to bank 3, then force it to sleep with a request pending
    do_req(1'b1, 10'h300, 32'h3333_0000, w, a);
    check("t4_wake_wait", 64'(w), 64'd5);
    do_req(1'b0, 10'h300, 32'h0, w, a);
    check("t4_b2b_0", 64'(w), 64'd0);
    do_req(1'b1, 10'h301, 32'h3333_0001, w, a);
    check("t4_b2b_1", 64'(w), 64'd0);
    do_req(1'b0, 10'h301, 32'h0, w, a);
    check("t4_b2b_2", 64'(w), 64'd0);
    req_we = 1'b0; req_addr = 10'h300; req_valid = 1'b1; force_sleep[3] = 1'b1;
    @(negedge clk);
    check("t4_ready_gated", 64'(req_ready), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("t4_forced_state", 64'(bank_state[7:6]), 64'h2);
      check("t4_forced_ready", 64'(req_ready), 64'd0);
      check("t4_forced_pwr", 64'(bank_pwr_en[3]), 64'd0);
    end
    @(posedge clk); #1;
    force_sleep[3] = 1'b0;
    do_req(1'b0, 10'h300, 32'h0, w, a);
    check("t4_rewake_wait", 64'(w), 64'd5);

    // Reset while bank 1 is waking with a stalled read
    check("t5_b1_sleep", 64'(bank_state[3:2]), 64'h2);
    req_we = 1'b0; req_addr = 10'h13C; req_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_b1_waking", 64'(bank_state[3:2]), 64'h1);
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    check("t5_state", 64'(bank_state), 64'h00);
    check("t5_pwr", 64'(bank_pwr_en), 64'hF);
    check("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t5_rsp_rdata", 64'(rsp_rdata), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_req(1'b0, 10'h13C, 32'h0, w, a);
    check("t5_b1_rd_wait", 64'(w), 64'd0);
    do_req(1'b0, 10'h005, 32'h0, w, a);
    check("t5_b0_rd_wait", 64'(w), 64'd0);

    // Access on the timeout cycle keeps the bank active
    repeat (15) @(posedge clk);
    #1;
    do_req(1'b0, 10'h010, 32'h0, w, a0);
    check("t6_acc_wait", 64'(w), 64'd0);
    check("t6_acc_cycle", 64'(a0), 64'(a + 16));
    @(negedge clk);
    check("t6_b0_active", 64'(bank_state[1:0]), 64'h0);
    @(posedge clk); #1;

    // Three forced sleep / wake cycles on bank 0
    repeat (3) begin
      force_sleep[0] = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      force_sleep[0] = 1'b0;
      do_req(1'b0, 10'h010, 32'h0, w, a);
      check("t7_wake_wait", 64'(w), 64'd5);
    end
`ifdef MEMBANK_WAKE_CNT_EN
    @(negedge clk);
    check("t7_wake_cnt_b0", 64'(bank_wake_cnt[15:0]), 64'd3);
    check("t7_wake_cnt_rest", 64'(bank_wake_cnt[63:16]), 64'd0);
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
